sigma_delta_adc: RTL

//  Two-channel first-order sigma-delta ADC front end with CIC decimator.
//  - Samples external comparator bits, drives them back as 1-bit feedback (external RC loop).
//  - Decimates each bitstream with a 3rd-order CIC filter to 18-bit signed PCM.
//  - Produces the same sample format the audio DAC path consumes.

---
 rtl/sigma_delta_adc.sv | 107 ++++++++++
 1 files changed

// File: rtl/sigma_delta_adc.sv
// Two-channel first-order sigma-delta ADC front end: comparator synchronisers,
// 1-bit feedback and 3rd-order CIC decimation (M = 1) to signed PCM.
module sigma_delta_adc #(
    parameter int unsigned DEC_LOG2 = 8,
    parameter int unsigned DW       = 18
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmp_l,
    input  logic          cmp_r,
    output logic          fb_l,
    output logic          fb_r,
    output logic [DW-1:0] ldata,
    output logic [DW-1:0] rdata,
    output logic          sample_stb
);
    localparam int unsigned   AW      = 3 * DEC_LOG2 + 1;
    localparam logic [AW:0]   HALF_FS = {2'b00, 1'b1, {(AW-2){1'b0}}};
    localparam logic [DW-1:0] PCM_MAX = {1'b0, {(DW-1){1'b1}}};

    // Channel index 0 = left, 1 = right throughout.
    logic [1:0]          r_sync1;
    logic [1:0]          r_sync2;
    logic [AW-1:0]       r_i1 [2];
    logic [AW-1:0]       r_i2 [2];
    logic [AW-1:0]       r_i3 [2];
    logic [AW-1:0]       r_d1 [2];
    logic [AW-1:0]       r_d2 [2];
    logic [AW-1:0]       r_d3 [2];
    logic [DW-1:0]       r_data [2];
    logic [DEC_LOG2-1:0] r_cnt;
    logic [2:0]          r_warm;
    logic                r_stb;

    logic                w_tick;
    logic [AW-1:0]       w_c1 [2];
    logic [AW-1:0]       w_c2 [2];
    logic [AW-1:0]       w_c3 [2];
    logic [AW:0]         w_s [2];
    logic [DW-1:0]       w_pcm [2];

    assign w_tick = &r_cnt;

    always_comb begin
        for (int unsigned ch = 0; ch < 2; ch++) begin
            w_c1[ch] = r_i3[ch] - r_d1[ch];
            w_c2[ch] = w_c1[ch] - r_d2[ch];
            w_c3[ch] = w_c2[ch] - r_d3[ch];
            w_s[ch]  = {1'b0, w_c3[ch]} - HALF_FS;
            // c3 is an unsigned count in [0, R^3], so s never drops below -HALF_FS
            if (!w_s[ch][AW] && (w_s[ch][AW-1] || w_s[ch][AW-2])) begin
                w_pcm[ch] = PCM_MAX;
            end else begin
                w_pcm[ch] = w_s[ch][AW-2 -: DW];
            end
        end
    end

    // Combs are combinational on the tick cycle; PCM and strobe register on the
    // edge that ends it, so sample_stb lags the all-ones count by one clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_cnt   <= '0;
            r_warm  <= '0;
            r_stb   <= 1'b0;
            for (int unsigned ch = 0; ch < 2; ch++) begin
                r_i1[ch]   <= '0;
                r_i2[ch]   <= '0;
                r_i3[ch]   <= '0;
                r_d1[ch]   <= '0;
                r_d2[ch]   <= '0;
                r_d3[ch]   <= '0;
                r_data[ch] <= '0;
            end
        end else begin
            r_sync1 <= {cmp_r, cmp_l};
            r_sync2 <= r_sync1;
            r_cnt   <= r_cnt + 1'b1;
            r_stb   <= w_tick && r_warm[2];
            if (w_tick && (r_warm != 3'd7)) begin
                r_warm <= r_warm + 3'd1;
            end
            for (int unsigned ch = 0; ch < 2; ch++) begin
                r_i1[ch] <= r_i1[ch] + {{(AW-1){1'b0}}, r_sync2[ch]};
                r_i2[ch] <= r_i2[ch] + r_i1[ch];
                r_i3[ch] <= r_i3[ch] + r_i2[ch];
                if (w_tick) begin
                    r_d1[ch] <= r_i3[ch];
                    r_d2[ch] <= w_c1[ch];
                    r_d3[ch] <= w_c2[ch];
                    if (r_warm[2]) begin
                        r_data[ch] <= w_pcm[ch];
                    end
                end
            end
        end
    end

    assign fb_l       = r_sync2[0];
    assign fb_r       = r_sync2[1];
    assign ldata      = r_data[0];
    assign rdata      = r_data[1];
    assign sample_stb = r_stb;

endmodule
